// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC serializer: FSM state encoding and frame geometry.
package dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = 5;
    localparam int DIV_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [FRAME_BITS-1:0] shift_msb_out(input logic [FRAME_BITS-1:0] frame);
        return {frame[FRAME_BITS-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/sclk_tick.sv
// Serial-clock divider: down-counter that emits a one-cycle tick every CLK_DIV enabled cycles.
module sclk_tick
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [DIV_CNT_W-1:0] RELOAD = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 w_tc;

    assign w_tc = (r_cnt == '0);

    // Held at the reload value while disabled so the first tick lands CLK_DIV cycles after enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || w_tc) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_en & w_tc;

endmodule

// File: rtl/dac_serializer.sv
// 16-bit frame serializer for an SPI-style DAC (sync_n/sclk/sdata, MSB first, sampled on sclk fall).
// Build option: define DAC_OFFSET_BINARY_EN to invert the sample MSB at capture (two's complement -> offset binary).
//
// state | meaning
// IDLE  | ready for load, lines parked (sync_n=1, sclk=1, sdata=0)
// SHIFT | frame on the wire, sync_n low, 16 sclk periods
// GAP   | sync_n high for CLK_DIV cycles, done on the last one
module dac_serializer
    import dac_pkg::*;
#(
    parameter int size    = 12,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] sample,
    input  logic            load,
    output logic            ready,
    output logic            done,
    output logic            sclk,
    output logic            sync_n,
    output logic            sdata
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_sclk;
    logic [FRAME_BITS-1:0]  w_frame;
    logic                   w_div_en;
    logic                   w_tick;
    logic                   w_rise;
    logic                   w_capture;
    logic                   w_ready;
    logic                   w_done;
    logic                   w_sync_n;
    logic                   w_sdata;

    always_comb begin
        w_frame             = '0;
        w_frame[size-1:0]   = sample;
`ifdef DAC_OFFSET_BINARY_EN
        w_frame[size-1]     = ~sample[size-1];
`endif
    end

    assign w_div_en  = (r_state != IDLE);
    assign w_rise    = w_tick & ~r_sclk;
    assign w_capture = (r_state == IDLE) & load;

    sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_div_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_sync_n    = 1'b1;
        w_sdata     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (load) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_sync_n = 1'b0;
                w_sdata  = r_shift[FRAME_BITS-1];
                // The 16th sclk rising edge closes the frame.
                if (w_rise && (r_bit_cnt == BIT_CNT_W'(1))) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (w_tick) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b1;
        end else if (w_capture) begin
            r_shift   <= w_frame;
            r_bit_cnt <= BIT_CNT_W'(FRAME_BITS);
            r_sclk    <= 1'b1;
        end else if ((r_state == SHIFT) && w_tick) begin
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
                r_shift   <= shift_msb_out(r_shift);
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
        end else if (r_state != SHIFT) begin
            r_sclk <= 1'b1;
        end
    end

    assign ready  = w_ready;
    assign done   = w_done;
    assign sync_n = w_sync_n;
    assign sdata  = w_sdata;
    assign sclk   = r_sclk;

endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench for dac_serializer: stimulus pushes expected frames, a wire-level monitor decodes and checks them.
module tb_dac_serializer;

    localparam int SIZE      = 12;
    localparam int DIV       = 2;
    localparam int FRAME_CYC = 32 * DIV;
    localparam int PERIOD    = 33 * DIV + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            load;
    logic [SIZE-1:0] sample;
    logic            ready;
    logic            done;
    logic            sclk;
    logic            sync_n;
    logic            sdata;

    dac_serializer #(
        .size    (SIZE),
        .CLK_DIV (DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sample (sample),
        .load   (load),
        .ready  (ready),
        .done   (done),
        .sclk   (sclk),
        .sync_n (sync_n),
        .sdata  (sdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] frame;
        int          start_edge;
    } exp_t;

    exp_t q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   free_at    = 0;
    int   n_exp_done = 0;
    int   n_done     = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [15:0] model_frame(input logic [SIZE-1:0] s);
        int v;
        v = int'(s);
`ifdef DAC_OFFSET_BINARY_EN
        v = v ^ (1 << (SIZE - 1));
`endif
        return 16'(v);
    endfunction

    // Acceptance rule: a load is taken only once a full frame period has elapsed since the last one.
    task automatic apply(input logic ld, input logic [SIZE-1:0] smp);
        bit   acc;
        exp_t e;
        load   = ld;
        sample = smp;
        if (ld) begin
            acc = (cyc >= free_at);
            check(ready == acc, "ready_model", int'(ready), int'(acc));
            if (acc) begin
                e.frame      = model_frame(smp);
                e.start_edge = cyc;
                q.push_back(e);
                free_at = cyc + PERIOD;
                n_exp_done++;
            end
        end
    endtask

    task automatic drive(input logic ld, input logic [SIZE-1:0] smp);
        @(negedge clk);
        apply(ld, smp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, SIZE'($urandom));
    endtask

    bit          mon_in_frame;
    bit          mon_prev_sclk;
    logic [15:0] mon_bits;
    int          mon_nbits;
    int          mon_low;
    int          mon_start;
    int          mon_post;
    exp_t        mon_e;

    initial begin
        mon_in_frame  = 0;
        mon_prev_sclk = 1;
        mon_bits      = '0;
        mon_nbits     = 0;
        mon_low       = 0;
        mon_start     = 0;
        mon_post      = -1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_in_frame  = 0;
                mon_post      = -1;
                mon_prev_sclk = 1;
            end else begin
                if (!sync_n) begin
                    if (!mon_in_frame) begin
                        mon_in_frame = 1;
                        mon_nbits    = 0;
                        mon_bits     = '0;
                        mon_low      = 0;
                        mon_start    = cyc;
                    end
                    mon_low++;
                    if (mon_prev_sclk && !sclk) begin
                        mon_bits = {mon_bits[14:0], sdata};
                        mon_nbits++;
                    end
                    if (done) check(0, "done_in_frame", 1, 0);
                end else begin
                    if (mon_in_frame) begin
                        mon_in_frame = 0;
                        mon_post     = 0;
                        check(mon_low == FRAME_CYC, "sync_n_low_len", mon_low, FRAME_CYC);
                        check(mon_nbits == 16, "bit_count", mon_nbits, 16);
                        if (q.size() == 0) begin
                            check(0, "frame_unexpected", int'(mon_bits), 0);
                        end else begin
                            mon_e = q.pop_front();
                            check(mon_bits == mon_e.frame, "frame_data", int'(mon_bits), int'(mon_e.frame));
                            check(mon_start == mon_e.start_edge + 1, "frame_start", mon_start, mon_e.start_edge + 1);
                        end
                    end else if (mon_post >= 0) begin
                        mon_post++;
                    end
                    check(sclk == 1'b1 && sdata == 1'b0, "idle_lines", int'({sclk, sdata}), 2);
                    if (mon_post == DIV - 1) begin
                        check(done == 1'b1, "done_pulse", int'(done), 1);
                        if (done) n_done++;
                    end else if (done) begin
                        check(0, "done_spurious", 1, 0);
                    end
                    if (mon_post == DIV) begin
                        check(ready == 1'b1, "ready_after_done", int'(ready), 1);
                        mon_post = -1;
                    end
                end
                mon_prev_sclk = sclk;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int accepted;
        int guard;
        rst    = 1'b1;
        load   = 1'b0;
        sample = '0;
        repeat (3) @(negedge clk);
        check(ready == 1'b1,  "rst_ready",  int'(ready),  1);
        check(sync_n == 1'b1, "rst_sync_n", int'(sync_n), 1);
        check(sclk == 1'b1,   "rst_sclk",   int'(sclk),   1);
        check(sdata == 1'b0,  "rst_sdata",  int'(sdata),  0);
        check(done == 1'b0,   "rst_done",   int'(done),   0);

        // Nominal frame, load on the very first edge after reset release.
        @(negedge clk);
        rst     = 1'b0;
        free_at = cyc;
        apply(1'b1, 12'hA5C);
        idle(80);

        // Busy rejection.
        drive(1'b1, 12'h123);
        idle(9);
        drive(1'b1, 12'hFFF);
        idle(80);

        // Abort at SHIFT cycle 20.
        drive(1'b1, 12'h3C5);
        idle(20);
        @(posedge clk);
        #2;
        rst = 1'b1;
        n_exp_done = n_exp_done - q.size();
        q.delete();
        #1;
        check(sync_n == 1'b1, "abort_sync_n", int'(sync_n), 1);
        check(sclk == 1'b1,   "abort_sclk",   int'(sclk),   1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        free_at = cyc;
        apply(1'b1, 12'h800);
        idle(80);

        // Back-to-back: load held high with a changing sample until three frames are taken.
        accepted = 0;
        guard    = 0;
        while (accepted < 3 && guard < 4 * PERIOD) begin
            @(negedge clk);
            if (cyc >= free_at) accepted++;
            apply(1'b1, SIZE'($urandom));
            guard++;
        end
        check(accepted == 3, "b2b_accepts", accepted, 3);
        idle(80);

        // Sign-bit boundary samples.
        drive(1'b1, 12'h7FF);
        idle(70);
        drive(1'b1, 12'h800);
        idle(70);

        // Random loads, many landing while busy.
        for (int i = 0; i < 700; i++) begin
            drive($urandom_range(0, 15) == 0, SIZE'($urandom));
        end

        guard = 0;
        while (q.size() != 0 && guard < 300) begin
            idle(1);
            guard++;
        end
        idle(2 * DIV + 2);
        check(q.size() == 0, "drain_queue", q.size(), 0);
        check(n_done == n_exp_done, "done_count", n_done, n_exp_done);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
